// File: rtl/exotiny_wb_console_tx_if.sv
// Wishbone-classic bus bundle between the ExoTiny data bus and the console TX responder.
`timescale 1ns/1ps
interface exotiny_wb_console_tx_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic        wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/exotiny_wb_console_tx.sv
// Console transmitter: Wishbone writes land in a small byte FIFO which is
// drained as 8N1 UART frames on tx_o. STATUS exposes FIFO and idle state.
`timescale 1ns/1ps
module exotiny_wb_console_tx #(
  parameter int CLKDIV     = 87,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_in,
  exotiny_wb_console_tx_if.slave        wb,
  output logic                          tx_o,
  output logic                          busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKDIV);
  localparam logic [CW-1:0] BAUD_RELOAD = CW'(CLKDIV - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  // Registered state
  state_t        state_q,   state_d;
  logic [CW-1:0] baud_q,    baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q,   shift_d;
  logic          tx_q,      tx_d;
  logic          busy_q,    busy_d;
  logic          ack_q,     ack_d;
  logic [31:0]   dat_q,     dat_d;
  logic [AW:0]   wr_ptr_q,  wr_ptr_d;
  logic [AW:0]   rd_ptr_q,  rd_ptr_d;

  // FIFO storage (no reset; contents are only meaningful between the pointers)
  logic [7:0] mem [FIFO_DEPTH];

  // Combinational helpers
  logic        req;
  logic        data_wr;
  logic        push;
  logic        pop;
  logic        fifo_empty;
  logic        fifo_full;
  logic [AW:0] fifo_count;
  logic [31:0] status_word;

  // Upper data byte lanes and sel bits other than [0] are deliberately ignored.
  logic unused_ok;
  assign unused_ok = ^{wb.wb_dat_i[31:8], wb.wb_sel_i[3:1]};

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign tx_o        = tx_q;
  assign busy_o      = busy_q;

  // FIFO flags: pointers carry an extra wrap bit so full and empty are distinct.
  always_comb begin
    fifo_count  = wr_ptr_q - rd_ptr_q;
    fifo_empty  = (wr_ptr_q == rd_ptr_q);
    fifo_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    status_word = {16'h0000, 8'(fifo_count), 5'b00000,
                   (fifo_empty && (state_q == ST_IDLE)), fifo_full, fifo_empty};
  end

  // Next-state logic for the bus responder, FIFO pointers and the TX FSM.
  always_comb begin
    // Bus side: full is judged on the current pointers, before any same-cycle pop.
    req     = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
    data_wr = req & wb.wb_we_i & ~wb.wb_adr_i & wb.wb_sel_i[0];
    push    = data_wr & ~fifo_full;
    ack_d   = req & ~(data_wr & fifo_full);
    dat_d   = '0;
    if (req && !wb.wb_we_i && wb.wb_adr_i) begin
      dat_d = status_word;
    end

    // TX side defaults: hold everything
    pop       = 1'b0;
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q[AW-1:0]];
          state_d = ST_START;
          baud_d  = BAUD_RELOAD;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (baud_q == '0) begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
          baud_d    = BAUD_RELOAD;
          tx_d      = shift_q[0];
        end else begin
          baud_d = baud_q - CW'(1);
        end
      end
      ST_DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_RELOAD;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            // Shifter always presents the current bit at [0]; next bit is [1].
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q - CW'(1);
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (baud_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);

    // Busy reflects the previous cycle so it lags a push by one cycle and
    // drops one cycle after the FSM returns to IDLE with nothing queued.
    busy_d = ~fifo_empty | (state_q != ST_IDLE);
  end

  // FIFO write port
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= wb.wb_dat_i[7:0];
    end
  end

  // State registers; reset is asynchronous so a frame in flight is cut immediately.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

endmodule

// File: tb/tb_exotiny_wb_console_tx.sv
// Scoreboard bench for the console transmitter: stimulus pushes expected bytes
// and read data into queues; monitors decode tx_o and watch wb_ack_o.
`timescale 1ns/1ps
module tb_exotiny_wb_console_tx;

  localparam int CLKDIV = 4;
  localparam int DEPTH  = 8;
  localparam int FRAME  = 10 * CLKDIV;

  logic clk;
  logic rst_n;
  logic tx;
  logic busy;

  exotiny_wb_console_tx_if wb();

  exotiny_wb_console_tx #(.CLKDIV(CLKDIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i  (clk),
    .rst_in (rst_n),
    .wb     (wb),
    .tx_o   (tx),
    .busy_o (busy)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc_cnt     = 0;

  logic [7:0]  tx_exp [$];
  logic [31:0] rd_exp [$];
  int          frame_starts [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc_cnt);
    end else begin
      $display("ok   %s: 0x%08h (cycle %0d)", name, act, cyc_cnt);
    end
  endtask

  // One bus transfer; returns number of negedges waited for the ack.
  task automatic wb_xfer(input logic we, input logic adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [31:0] rexp, output int waited);
    @(negedge clk);
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    wb.wb_we_i  = we;
    wb.wb_adr_i = adr;
    wb.wb_dat_i = dat;
    wb.wb_sel_i = sel;
    if (!we) rd_exp.push_back(rexp);
    if (we && !adr && sel[0]) tx_exp.push_back(dat[7:0]);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!wb.wb_ack_o && waited < 300);
    if (!wb.wb_ack_o) check("ack_timeout", 32'(waited), 32'd0);
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
  endtask

  task automatic wb_write(input logic adr, input logic [31:0] dat, input logic [3:0] sel,
                          output int waited);
    wb_xfer(1'b1, adr, dat, sel, 32'h0, waited);
  endtask

  task automatic wb_read(input logic adr, input logic [31:0] rexp);
    int w;
    wb_xfer(1'b0, adr, 32'h0, 4'hF, rexp, w);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((tx_exp.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(tx_exp.size()), 32'd0);
  endtask

  // Read monitor: compares read data on each read ack, then checks the bus idles to 0.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && wb.wb_ack_o && !wb.wb_we_i) begin
        if (rd_exp.size() == 0) begin
          check("unexpected_read_ack", wb.wb_dat_o, 32'hDEADBEEF);
        end else begin
          e = rd_exp.pop_front();
          check("read_data", wb.wb_dat_o, e);
        end
        @(negedge clk);
        check("dat_zero_after_ack", wb.wb_dat_o, 32'h0);
      end
    end
  end

  // Ack pulse monitor: ack may never be high two cycles running.
  initial begin
    logic prev_ack;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (wb.wb_ack_o) check("ack_single_cycle", 32'(prev_ack), 32'd0);
      prev_ack = wb.wb_ack_o;
    end
  end

  // UART monitor: captures 40 samples from the start bit and decodes the frame.
  initial begin
    logic       smp [FRAME];
    logic       aborted;
    logic       shape_ok;
    logic [7:0] byte_v;
    logic [7:0] e;
    int         start_cyc;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        aborted   = 1'b0;
        start_cyc = cyc_cnt;
        smp[0]    = tx;
        for (int i = 1; i < FRAME; i++) begin
          @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          smp[i] = tx;
        end
        if (!aborted) begin
          frame_starts.push_back(start_cyc);
          shape_ok = 1'b1;
          for (int k = 0; k < CLKDIV; k++) begin
            if (smp[k] !== 1'b0) shape_ok = 1'b0;
            if (smp[9*CLKDIV + k] !== 1'b1) shape_ok = 1'b0;
          end
          for (int b = 0; b < 8; b++) begin
            byte_v[b] = smp[(b+1)*CLKDIV];
            for (int k = 1; k < CLKDIV; k++)
              if (smp[(b+1)*CLKDIV + k] !== byte_v[b]) shape_ok = 1'b0;
          end
          check("frame_shape", 32'(shape_ok), 32'd1);
          if (tx_exp.size() == 0) begin
            check("unexpected_frame", 32'(byte_v), 32'h100);
          end else begin
            e = tx_exp.pop_front();
            check("tx_byte", 32'(byte_v), 32'(e));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         w;
    logic       all_high;
    logic [7:0] msg [4];
    msg[0] = 8'h44; msg[1] = 8'h4F; msg[2] = 8'h4E; msg[3] = 8'h45;

    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    wb.wb_adr_i = 1'b0; wb.wb_dat_i = 32'h0; wb.wb_sel_i = 4'h0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx",   32'(tx), 32'd1);
    check("rst_ack",  32'(wb.wb_ack_o), 32'd0);
    check("rst_dat",  wb.wb_dat_o, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    wb_read(1'b1, 32'h0000_0005);
    wb_read(1'b0, 32'h0000_0000);

    // Single 'D': latency, frame length, busy drop
    wb_write(1'b0, 32'h0000_0044, 4'h1, w);
    check("d_ack_wait", 32'(w), 32'd1);
    check("d_tx_high_at_ack", 32'(tx), 32'd1);
    check("d_busy_at_ack", 32'(busy), 32'd0);
    @(negedge clk);
    check("d_tx_start", 32'(tx), 32'd0);
    check("d_busy_set", 32'(busy), 32'd1);
    repeat (FRAME) @(negedge clk);
    check("d_tx_idle_after", 32'(tx), 32'd1);
    check("d_busy_last", 32'(busy), 32'd1);
    @(negedge clk);
    check("d_busy_drop", 32'(busy), 32'd0);

    // "DONE" back to back
    frame_starts.delete();
    for (int i = 0; i < 4; i++) begin
      wb_write(1'b0, {24'h0, msg[i]}, 4'hF, w);
      check("done_ack_wait", 32'(w), 32'd1);
    end
    wait_drain("done_drain");
    check("done_frames", 32'(frame_starts.size()), 32'd4);
    for (int i = 1; i < 4 && i < frame_starts.size(); i++)
      check("done_spacing", 32'(frame_starts[i] - frame_starts[i-1]), 32'(FRAME + 1));

    // Byte lane 0 disabled: acked, nothing queued
    wb_write(1'b0, 32'h0000_0041, 4'b0010, w);
    check("sel_ack_wait", 32'(w), 32'd1);
    wb_read(1'b1, 32'h0000_0005);
    all_high = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1) all_high = 1'b0;
    end
    check("sel_tx_idle", 32'(all_high), 32'd1);

    // Ten bytes into an 8-deep FIFO: 10th stalls until the first frame ends
    for (int i = 0; i < 9; i++) begin
      wb_write(1'b0, 32'h30 + 32'(i), 4'h1, w);
      check("burst_ack_wait", 32'(w), 32'd1);
    end
    wb_read(1'b1, 32'h0000_0802);
    wb_write(1'b0, 32'h39, 4'h1, w);
    check("burst_stall", 32'(w > 10), 32'd1);
    wait_drain("burst_drain");

    // Three writes while a frame runs
    for (int i = 0; i < 3; i++) wb_write(1'b0, 32'h61 + 32'(i), 4'h1, w);
    wb_read(1'b1, 32'h0000_0200);
    wait_drain("abc_drain");

    // Reset during data bit 3 of 0x55 (bit 3 is 0)
    wb_write(1'b0, 32'h55, 4'h1, w);
    wb_write(1'b0, 32'h56, 4'h1, w);
    wb_write(1'b0, 32'h57, 4'h1, w);
    repeat (14) @(negedge clk);
    check("rst_mid_bit3_low", 32'(tx), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_tx", 32'(tx), 32'd1);
    check("rst_mid_ack", 32'(wb.wb_ack_o), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    tx_exp.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wb_read(1'b1, 32'h0000_0005);
    all_high = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) all_high = 1'b0;
    end
    check("rst_no_residual", 32'(all_high), 32'd1);
    check("final_tx_queue", 32'(tx_exp.size()), 32'd0);
    check("final_rd_queue", 32'(rd_exp.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
